addsub_sweep_ctrl: RTL and testbench
====================================

# addsub_sweep_ctrl

- Sequencing FSM for the 16-bit up/down counter datapath.
- Drives the datapath's `ld`, `clr` and `s` controls and consumes its `CM` (at upper limit) and `Cm` (at lower limit) flags.
- Produces paced triangle sweeps of `C`: clear, count up to the limit, count down to the limit, then finish or repeat.
- Sits between the top-level user/host interface and the datapath; owns the pacing, the sweep count and the start/stop/done handshake.

## Interface
- `PRESCALE_W`, 8, width of the step-rate divider. Load period is `prescale`+1 cycles.
- `SWEEP_W`, 8, width of the completed-sweep counter.
- `clk` in 1: single system clock; everything on its rising edge.
- `rst` in 1: **asynchronous, active-high** reset.
- `start` in 1: level-sampled request to begin a run; accepted only in IDLE.
- `stop` in 1: abort request; takes priority over `start` and over all other transitions.
- `continuous` in 1: 1 = repeat sweeps until `stop`; 0 = one sweep then DONE. Sampled every cycle.
- `prescale` in PRESCALE_W: step period minus one; latched when `start` is accepted.
- `CM` in 1: datapath counter at upper limit.
- `Cm` in 1: datapath counter at lower limit.
- `ld` out 1: datapath load enable.
- `clr` out 1: datapath synchronous clear.
- `s` out 1: datapath direction; 0 = increment, 1 = decrement.
- `busy` out 1: high in CLEAR, UP and DOWN.
- `done` out 1: one-cycle pulse in DONE.
- `sweeps` out SWEEP_W: completed up+down sweeps since the last accepted `start`; saturating.

## Operation
States: IDLE, CLEAR, UP, DOWN, DONE.

- **IDLE**
  - `start`=1 and `stop`=0: go to CLEAR, latch `prescale`, zero `sweeps`.
  - Otherwise: stay in IDLE.
- **CLEAR**
  - `clr`=1 for exactly one cycle.
  - Next state: UP, or IDLE if `stop`.
- **UP**
  - `s`=0.
  - On a tick with `CM`=1: go to DOWN with `ld`=0, so the counter never wraps past its maximum.
  - On a tick with `CM`=0: `ld`=1.
- **DOWN**
  - `s`=1.
  - On a tick with `Cm`=0: `ld`=1.
  - On a tick with `Cm`=1: `ld`=0 and `sweeps` increments, saturating at all-ones. Next state is UP if `continuous`, else DONE.
- **DONE**
  - `done`=1.
  - Next state: IDLE unconditionally.
- **stop** in CLEAR, UP or DOWN:
  - Next state is IDLE.
  - That cycle's `ld` is forced to 0.
  - `C` holds its value and `sweeps` holds.
- **Tick generation**
  - A prescaler counter resets to 0 on entry to UP or DOWN and on every tick.
  - tick = (count == latched prescale).
  - A tick is evaluated only in UP/DOWN.
- **Output rules**
  - `ld`, `clr` and `s` are decoded from registered state, the prescaler count and `CM`/`Cm` only.
  - There is no combinational path from `start`, `stop` or `continuous` to any output, except `ld` being gated by `stop`.
  - `ld` and `clr` are never high together.
- **Reset**
  - State returns to IDLE and the prescaler to 0.
  - All outputs go to 0: `ld`=`clr`=`s`=`busy`=`done`=0, `sweeps`=0.
  - Reset mid-run aborts immediately. The datapath shares `rst`, so `C` is also 0.

## Timing
- `start` sampled at edge 0 puts CLEAR in cycle 1 with `clr`=1 and `busy`=1.
- UP begins in cycle 2. The first tick, and `ld`=1 if `CM`=0, falls in cycle 2+`prescale`.
- With `prescale`=0, a tick occurs every cycle in UP/DOWN, giving a sustained `ld`=1 stream.
- Each direction reversal costs one tick period with no load.
- `done` is high the cycle after the final DOWN tick. `busy` falls in that same cycle.
- `stop` sampled at edge n puts IDLE in cycle n+1.

## Structure
- Shared package `addsub_ctrl_pkg` holds:
  - state enum `sweep_state_t`.
  - `PRESCALE_W_DEF` and `SWEEP_W_DEF` constants.
- One sub-module, `rate_prescaler`:
  - Inputs: `clk`, `rst`, `restart`, `period`.
  - Output: `tick`.
  - Instantiated once.
- Top module holds the FSM, the `sweeps` counter and the `prescale` latch.

## Test plan
- **Reset mid-run:** assert `rst` while in DOWN with `ld`=1 → same cycle `ld`=`s`=`busy`=0, `sweeps`=0; IDLE after release.
- **Single sweep, unpaced:** `prescale`=0, `continuous`=0; datapath bench limits 0..3 → `clr` one cycle, then:
  - `ld` ×3 with `s`=0,
  - one idle reversal cycle, `ld` ×3 with `s`=1, one idle cycle,
  - then `done` pulse, `sweeps`=1, `C`=0.
- **Pacing:** `prescale`=4 → `ld` pulses exactly every 5 cycles in UP; first pulse in cycle 6 after `start`.
- **Continuous run:**
  - `continuous`=1 for 3 sweeps, then `stop` mid-UP → `sweeps`=3, `busy` drops the next cycle, `C` frozen, no `done`.
  - Separately, `start`=`stop`=1 in IDLE → remains IDLE.
- **Saturation:** `SWEEP_W`=2, `continuous`=1, 5 sweeps → `sweeps` stays 3. `start` while busy → ignored, `sweeps` unaffected.

Source files
------------

// File: rtl/addsub_ctrl_pkg.sv
// Shared definitions for the up/down counter sweep controller.
//   sweep_state_t   : controller state encoding
//   PRESCALE_W_DEF  : default width of the step-rate divider
//   SWEEP_W_DEF     : default width of the completed-sweep counter
//   is_stepping()   : true in the states where the datapath may be loaded
package addsub_ctrl_pkg;

  localparam int PRESCALE_W_DEF = 8;
  localparam int SWEEP_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_UP    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_t;

  function automatic logic is_stepping(input sweep_state_t st);
    return (st == ST_UP) || (st == ST_DOWN);
  endfunction

endpackage

// File: rtl/addsub_sweep_ctrl_rate_prescaler.sv
// Step-rate divider for the sweep controller.
//   clk, rst : system clock, asynchronous active-high reset
//   restart  : hold the count at 0 (asserted whenever stepping is not active)
//   period   : tick period minus one
//   tick     : high for one cycle every period+1 cycles while restart is low
module rate_prescaler
  import addsub_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // Gating with restart keeps tick clean outside UP/DOWN even though the
  // period latch is not reset.
  assign tick = !restart && (count == period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/addsub_sweep_ctrl.sv
// Sequencing FSM for the 16-bit up/down counter datapath. Produces paced
// triangle sweeps: clear, count up to the upper limit, count down to the
// lower limit, then finish or repeat.
//   clk, rst    : system clock, asynchronous active-high reset
//   start       : run request, accepted only in IDLE
//   stop        : abort, highest priority
//   continuous  : 1 = repeat sweeps until stop, 0 = one sweep then DONE
//   prescale    : step period minus one, latched when start is accepted
//   CM, Cm      : datapath at upper / lower limit
//   ld, clr, s  : datapath load enable, synchronous clear, direction (1=down)
//   busy        : high in CLEAR, UP and DOWN
//   done        : one-cycle pulse after the final down step
//   sweeps      : saturating count of completed up+down sweeps
module addsub_sweep_ctrl
  import addsub_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int SWEEP_W    = SWEEP_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  CM,
  input  logic                  Cm,
  output logic                  ld,
  output logic                  clr,
  output logic                  s,
  output logic                  busy,
  output logic                  done,
  output logic [SWEEP_W-1:0]    sweeps
);

  sweep_state_t          state;
  sweep_state_t          state_nxt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick;
  logic                  accept;
  logic                  sweep_end;

  function automatic logic [SWEEP_W-1:0] sat_inc(input logic [SWEEP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept    = (state == ST_IDLE) && start && !stop;
  assign sweep_end = (state == ST_DOWN) && tick && Cm && !stop;

  // Prescaler is held at 0 outside UP/DOWN, so it starts from 0 on every
  // entry into UP from CLEAR; UP<->DOWN changes happen on ticks, which
  // restart it anyway.
  rate_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .restart(!is_stepping(state)),
    .period (prescale_q),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = stop ? ST_IDLE : ST_UP;
      end
      ST_UP: begin
        if (stop)            state_nxt = ST_IDLE;
        else if (tick && CM) state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (stop)            state_nxt = ST_IDLE;
        else if (tick && Cm) state_nxt = continuous ? ST_UP : ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweeps <= '0;
    end else if (accept) begin
      sweeps <= '0;
    end else if (sweep_end) begin
      sweeps <= sat_inc(sweeps);
    end
  end

  // Step period is only consumed in UP/DOWN, after it has been loaded here.
  always_ff @(posedge clk) begin
    if (accept) begin
      prescale_q <= prescale;
    end
  end

  // A tick at a limit is the reversal/finish step and never loads, so the
  // counter cannot wrap; stop is the only input allowed to reach ld.
  assign ld   = !stop && tick &&
                (((state == ST_UP) && !CM) || ((state == ST_DOWN) && !Cm));
  assign clr  = (state == ST_CLEAR);
  assign s    = (state == ST_DOWN);
  assign busy = (state == ST_CLEAR) || is_stepping(state);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_addsub_sweep_ctrl.sv
// Bench for addsub_sweep_ctrl: a behavioural model of the 16-bit datapath
// (limits 0..lim_hi) closes the loop; a second instance with a 2-bit sweep
// counter shares the same stimulus for the saturation case.
module tb_addsub_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, continuous;
  logic [7:0]  prescale;
  logic        CM, Cm;
  logic        ld, clr, s, busy, done;
  logic [7:0]  sweeps;
  logic        ld2, clr2, s2, busy2, done2;
  logic [1:0]  sweeps2;
  logic [15:0] C;
  logic [15:0] lim_hi = 16'd3;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  typedef struct packed {
    logic        ld, clr, s, busy, done;
    logic [7:0]  sweeps;
    logic [15:0] c;
  } exp_t;

  typedef struct {
    logic start, stop, cont;
    exp_t exp;
  } vec_t;

  vec_t vecs[14];
  exp_t sb[$];

  always #5 clk = ~clk;

  addsub_sweep_ctrl #(.PRESCALE_W(8), .SWEEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .prescale(prescale), .CM(CM), .Cm(Cm),
    .ld(ld), .clr(clr), .s(s), .busy(busy), .done(done), .sweeps(sweeps)
  );

  addsub_sweep_ctrl #(.PRESCALE_W(8), .SWEEP_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .prescale(prescale), .CM(CM), .Cm(Cm),
    .ld(ld2), .clr(clr2), .s(s2), .busy(busy2), .done(done2), .sweeps(sweeps2)
  );

  // Datapath model: shares rst, clears synchronously, steps on ld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      C <= 16'd0;
    else if (clr) C <= 16'd0;
    else if (ld)  C <= s ? C - 16'd1 : C + 16'd1;
  end
  assign CM = (C == lim_hi);
  assign Cm = (C == 16'd0);

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  function automatic vec_t mk(input int st, sp, co, l, cl, sd, b, d, sw, c);
    vec_t v;
    v.start = st[0]; v.stop = sp[0]; v.cont = co[0];
    v.exp.ld = l[0]; v.exp.clr = cl[0]; v.exp.s = sd[0];
    v.exp.busy = b[0]; v.exp.done = d[0];
    v.exp.sweeps = sw[7:0]; v.exp.c = c[15:0];
    return v;
  endfunction

  // Wait (at negedges) until sweeps reaches target, within a cycle budget.
  task automatic wait_sweeps(input string name, input logic [7:0] target, input int budget);
    for (int n = 0; n < budget && sweeps != target; n++) @(negedge clk);
    check(name, 64'(sweeps), 64'(target));
  endtask

  initial begin
    int   up_hits[$];
    int   dn_hits[$];
    int   done_cyc;
    int   dc0;
    exp_t got, want;

    // Single unpaced sweep (limits 0..3) followed by start+stop in IDLE.
    //             st sp co  ld clr s busy done sw  C
    vecs[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 0, 0,  0, 1, 0, 1, 0,  0, 0);
    vecs[2]  = mk(0, 0, 0,  1, 0, 0, 1, 0,  0, 0);
    vecs[3]  = mk(0, 0, 0,  1, 0, 0, 1, 0,  0, 1);
    vecs[4]  = mk(0, 0, 0,  1, 0, 0, 1, 0,  0, 2);
    vecs[5]  = mk(0, 0, 0,  0, 0, 0, 1, 0,  0, 3);
    vecs[6]  = mk(0, 0, 0,  1, 0, 1, 1, 0,  0, 3);
    vecs[7]  = mk(0, 0, 0,  1, 0, 1, 1, 0,  0, 2);
    vecs[8]  = mk(0, 0, 0,  1, 0, 1, 1, 0,  0, 1);
    vecs[9]  = mk(0, 0, 0,  0, 0, 1, 1, 0,  0, 0);
    vecs[10] = mk(0, 0, 0,  0, 0, 0, 0, 1,  1, 0);
    vecs[11] = mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0);
    vecs[12] = mk(1, 1, 0,  0, 0, 0, 0, 0,  1, 0);
    vecs[13] = mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0);

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; prescale = 8'd0;
    @(negedge clk);
    check("reset_state", 64'({ld, clr, s, busy, done, sweeps, ld2, clr2, s2, busy2, done2, sweeps2}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_release", 64'({ld, clr, s, busy, done, sweeps, C}), 64'd0);

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      start = vecs[i].start; stop = vecs[i].stop; continuous = vecs[i].cont;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      got  = {ld, clr, s, busy, done, sweeps, C};
      want = sb.pop_front();
      check($sformatf("vec%0d", i), 64'(got), 64'(want));
    end

    // Pacing: prescale=4, one sweep; start sampled at edge 0.
    @(posedge clk); #1;
    prescale = 8'd4; continuous = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (ld && !s) up_hits.push_back(cyc);
      if (ld && s)  dn_hits.push_back(cyc);
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    check("pace_up_count", 64'(up_hits.size()), 64'd3);
    check("pace_dn_count", 64'(dn_hits.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pace_up%0d", k), 64'((k < up_hits.size()) ? up_hits[k] : -1), 64'(6 + 5 * k));
      check($sformatf("pace_dn%0d", k), 64'((k < dn_hits.size()) ? dn_hits[k] : -1), 64'(26 + 5 * k));
    end
    check("pace_done_cycle", 64'(done_cyc), 64'd42);
    check("pace_sweeps", 64'(sweeps), 64'd1);

    // Continuous run, stop mid-UP after 3 sweeps.
    prescale = 8'd0; continuous = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc0 = done_cnt;
    wait_sweeps("cont_reach3", 8'd3, 200);
    @(posedge clk); #1;
    stop = 1'b1;
    @(negedge clk);
    check("stop_ld_gated", 64'({ld, busy, s}), 64'b010);
    check("stop_c_value", 64'(C), 64'd1);
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_idle", 64'({busy, done, clr, ld}), 64'd0);
    check("stop_sweeps", 64'(sweeps), 64'd3);
    repeat (3) @(negedge clk);
    check("stop_c_frozen", 64'(C), 64'd1);
    check("stop_no_done", 64'(done_cnt - dc0), 64'd0);

    // Saturation on the 2-bit instance, and start ignored while busy.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_sweeps("sat_reach1", 8'd1, 200);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored", 64'({busy, sweeps}), 64'({1'b1, 8'd1}));
    wait_sweeps("sat_reach5", 8'd5, 300);
    check("sat_sweeps2", 64'(sweeps2), 64'd3);
    check("sat_ctrl_match", 64'({ld2, clr2, s2, busy2, done2}), 64'({ld, clr, s, busy, done}));

    // Reset asserted mid-run while DOWN is loading.
    for (int n = 0; n < 50 && !(s && ld); n++) @(negedge clk);
    check("rst_pre_down_ld", 64'({s, ld}), 64'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_run", 64'({ld, s, busy, sweeps, sweeps2, C}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; continuous = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_then_idle", 64'({ld, clr, s, busy, done, sweeps, C}), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
